uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one byte-level UART transmitter among NUM_REQ message sources, e.g. the frequency
//  report and status or echo streams. Arbitration is packet-level round-robin: a granted source
//  keeps the transmitter until its last byte is accepted or MAX_PKT_LEN bytes have passed.
//  Sits between the message formatters and the UART TX serializer (8N1, DELAY_FRAMES per bit).
// PARAMETERS
//  NUM_REQ      2   number of requesters, 2..8
//  MAX_PKT_LEN  16  byte limit per grant; forced release when reached
//  TIMEOUT_CYC  4096  stall limit in clk cycles; used only with UART_SCHED_TIMEOUT_EN
// PORTS
//  clk        in   1          system clock, 61.44 MHz
//  rst        in   1          asynchronous reset, active-high
//  req_valid  in   NUM_REQ    per-source byte valid
//  req_data   in   8*NUM_REQ  per-source byte; source i occupies bits [8i+7:8i]
//  req_last   in   NUM_REQ    marks the final byte of a packet; qualified by req_valid
//  req_ready  out  NUM_REQ    per-source accept; only the granted bit can be 1
//  tx_data    out  8          byte to the serializer
//  tx_valid   out  1          byte valid to the serializer
//  tx_ready   in   1          serializer can take a byte
//  grant_id   out  3          index of the current or last granted source
//  busy       out  1          1 while in STREAM
//  pkt_trunc  out  1          1-cycle pulse when a packet is force-closed at MAX_PKT_LEN
//  abort      out  1          1-cycle pulse on timeout release; held 0 without the macro
// BEHAVIOUR
//  - Reset: state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1 (source 0 wins first), byte_cnt=0.
//    All outputs are 0 during reset. A reset mid-packet drops the packet with no flush.
//  - Handshake: a byte transfers on a cycle where tx_valid && tx_ready are both 1.
//  - IDLE: tx_valid=0, req_ready=0. If any req_valid is 1, the source after rr_ptr (with
//    wrap-around) wins. grant_id, rr_ptr and byte_cnt=0 register next cycle; state goes to STREAM.
//    Arbitration latency is 1 cycle. No request means IDLE holds.
//  - STREAM: tx_data, tx_valid and req_ready[grant_id] are a combinational pass-through:
//    tx_data=req_data[grant_id], tx_valid=req_valid[grant_id], req_ready[grant_id]=tx_ready.
//    Other req_ready bits are 0. byte_cnt increments on each transfer.
//  - Release: a transfer with req_last=1 returns the state to IDLE. A transfer with
//    byte_cnt==MAX_PKT_LEN-1 and req_last=0 also returns to IDLE and pulses pkt_trunc.
//  - One IDLE cycle always separates packets. A source with pending data after release
//    is re-granted only if no other source is requesting.
//  - Requests arriving in STREAM from non-granted sources wait. There is no pre-emption.
//  - busy=1 exactly while in STREAM. grant_id holds its value through IDLE.
//  - A req_valid deassert inside a packet is legal: tx_valid follows it and the grant holds.
//  - byte_cnt width is $clog2(MAX_PKT_LEN+1), so it never wraps.
// CONFIGURATION
//  UART_SCHED_TIMEOUT_EN defined:
//    - In STREAM, stall_cnt counts cycles where req_valid[grant_id]=0 and resets on a transfer.
//    - At stall_cnt==TIMEOUT_CYC-1: go to IDLE, pulse abort for 1 cycle, clear stall_cnt.
//  UART_SCHED_TIMEOUT_EN undefined: no stall counter, abort tied to 0, grant held indefinitely.
// STRUCTURE
//  Package uart_pkg:
//    - sched_state_t enum {IDLE, STREAM}
//    - UART_BYTE_W=8, GRANT_ID_W=3
//    - DELAY_FRAMES shared with the serializer
//  Sub-module rr_pick: combinational round-robin picker.
//    - Inputs: req vector, rr_ptr. Outputs: found, index.
//    - Instantiated once.
// TESTING
//  1. Reset, then source0 sends 3 bytes 0x31,0x32,0x0D(last) with tx_ready=1
//     -> tx_data shows 0x31,0x32,0x0D; busy for 3 cycles; IDLE after.
//  2. Both sources valid continuously, 2-byte packets
//     -> grant order 0,1,0,1; one IDLE cycle between packets.
//  3. Source1 streams while source0 raises valid mid-packet
//     -> source0 waits; req_ready[0]=0 until source1's last byte.
//  4. Source0 sends 16 bytes with no last, MAX_PKT_LEN=16
//     -> pkt_trunc pulses on byte 16; next grant goes to source1 if it is requesting.
//  5. tx_ready held 0 for 600 cycles mid-packet
//     -> no bytes lost or duplicated; grant held; byte_cnt frozen.
//  6. With UART_SCHED_TIMEOUT_EN, TIMEOUT_CYC=8, source0 drops valid after byte 1
//     -> abort pulses 8 cycles later; IDLE; next grant follows round-robin. Assert rst mid-packet
//     -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The scheduler and the serializer both import this package so that the
// byte width, grant index width and bit timing stay in agreement.
package uart_pkg;

    // Scheduler state: waiting for a requester, or streaming one packet
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sched_state_t;

    localparam int UART_BYTE_W  = 8;
    localparam int GRANT_ID_W   = 3;

    // 61.44 MHz / 115200 baud, rounded down; clock cycles per serial bit
    localparam int DELAY_FRAMES = 533;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector starting at the source after rr_ptr, wrapping
// around, and reports the first requesting source.
import uart_pkg::*;

module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]    req,
    input  logic [GRANT_ID_W-1:0] rr_ptr,
    output logic                  found,
    output logic [GRANT_ID_W-1:0] index
);

    // Walk distances 1..NUM_REQ from rr_ptr; the first hit has priority
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(rr_ptr) + k) % NUM_REQ))) begin
                    found = 1'b1;
                    index = GRANT_ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-level round-robin scheduler sharing one UART byte transmitter
// among NUM_REQ message sources. A granted source keeps the transmitter
// until its last byte is taken or MAX_PKT_LEN bytes have gone through.
// Optional feature macro: UART_SCHED_TIMEOUT_EN releases a grant whose
// source has stalled for TIMEOUT_CYC cycles and pulses abort.
import uart_pkg::*;

module uart_tx_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int MAX_PKT_LEN = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [GRANT_ID_W-1:0]          grant_id,
    output logic                           busy,
    output logic                           pkt_trunc,
    output logic                           abort
);

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    sched_state_t           state, state_nxt;
    logic [GRANT_ID_W-1:0]  grant_nxt;
    logic [GRANT_ID_W-1:0]  rr_ptr, rr_nxt;
    logic [CNT_W-1:0]       byte_cnt, cnt_nxt;
    logic                   trunc_nxt;

    logic                   pick_found;
    logic [GRANT_ID_W-1:0]  pick_idx;

    logic                   sel_valid;
    logic                   sel_last;
    logic [UART_BYTE_W-1:0] sel_data;
    logic                   xfer;
    logic                   stall_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    // Select the granted source's byte, valid and last flag
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GRANT_ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[UART_BYTE_W*i +: UART_BYTE_W];
            end
        end
    end

    assign busy     = (state == STREAM);
    assign tx_valid = busy && sel_valid;
    assign tx_data  = busy ? sel_data : '0;
    assign xfer     = tx_valid && tx_ready;

    // Only the granted source sees the serializer's ready while streaming
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (busy && (grant_id == GRANT_ID_W'(i))) begin
                req_ready[i] = tx_ready;
            end
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_cnt, stall_nxt;

    // The release fires on the TIMEOUT_CYC-th consecutive cycle without valid
    assign stall_hit = busy && !sel_valid && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

    // Count stalled cycles of the granted source; any transfer or release clears it
    always_comb begin
        stall_nxt = stall_cnt;
        if (!busy || xfer || stall_hit) begin
            stall_nxt = '0;
        end else if (!sel_valid) begin
            stall_nxt = stall_cnt + STALL_W'(1);
        end
    end

    // Stall counter and the registered abort pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            abort     <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            abort     <= stall_hit;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYC;
    assign stall_hit          = 1'b0;
    assign abort              = 1'b0;
`endif

    // Arbitration in IDLE, packet tracking and release decisions in STREAM
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        cnt_nxt   = byte_cnt;
        trunc_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    rr_nxt    = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    cnt_nxt = byte_cnt + CNT_W'(1);
                    if (sel_last) begin
                        state_nxt = IDLE;
                    end else if (byte_cnt == CNT_W'(MAX_PKT_LEN - 1)) begin
                        state_nxt = IDLE;
                        trunc_nxt = 1'b1;
                    end
                end else if (stall_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and arbitration registers; pkt_trunc is a registered pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= GRANT_ID_W'(NUM_REQ - 1);
            byte_cnt  <= '0;
            pkt_trunc <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            rr_ptr    <= rr_nxt;
            byte_cnt  <= cnt_nxt;
            pkt_trunc <= trunc_nxt;
        end
    end

endmodule
